serial_adder: RTL and testbench

- Bit-serial, parametrised-width adder/subtractor built around one full-adder slice and a registered carry.
- Adds or subtracts two WIDTH-bit words, LSB first, one bit per clock, with a start/busy/done handshake.
- Adds carry-in, subtract mode and signed-overflow detection to the single-bit adder.
- Trades latency for area in ALU datapaths where a WIDTH-bit ripple adder is too large.

---
 rtl/serial_adder_if.sv | 64 ++++++
 rtl/serial_adder.sv | 130 +++++++++++++
 tb/tb_serial_adder.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// ---------------------------------------------------------------------------
// serial_adder_if
//
// Purpose:
//   Bundles the operation handshake and data bus of the bit-serial
//   adder/subtractor so that the requester and the adder can be connected
//   through a single port.
//
// Signals:
//   start     requester -> adder   request to begin an operation
//   i1        requester -> adder   operand A (WIDTH bits)
//   i2        requester -> adder   operand B (WIDTH bits)
//   cin       requester -> adder   carry-in for add, ignored for subtract
//   sub       requester -> adder   0 = i1+i2+cin, 1 = i1-i2
//   busy      adder -> requester   bits are being processed
//   done      adder -> requester   one-cycle result-valid pulse
//   sum       adder -> requester   result (WIDTH bits)
//   carry     adder -> requester   carry out of the MSB (sub: 1 = no borrow)
//   overflow  adder -> requester   signed overflow
//
// Modports:
//   master  the requester side (drives operands and start)
//   slave   the adder side (drives status and result)
// ---------------------------------------------------------------------------
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] i1;
    logic [WIDTH-1:0] i2;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;

    modport master (
        output start,
        output i1,
        output i2,
        output cin,
        output sub,
        input  busy,
        input  done,
        input  sum,
        input  carry,
        input  overflow
    );

    modport slave (
        input  start,
        input  i1,
        input  i2,
        input  cin,
        input  sub,
        output busy,
        output done,
        output sum,
        output carry,
        output overflow
    );
endinterface

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Purpose:
//   Bit-serial WIDTH-bit adder/subtractor built from a single full-adder
//   slice and a registered carry. Operands are processed LSB first, one bit
//   per clock, giving a latency of WIDTH+1 cycles from the accepted start to
//   the done pulse. Subtraction is performed as i1 + ~i2 + 1. Signed
//   overflow is the carry into the MSB XOR the carry out of the MSB.
//
// Parameters:
//   WIDTH     operand and result width in bits (>= 1)
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous, active-high reset (highest priority)
//   bus       serial_adder_if slave modport:
//               start/i1/i2/cin/sub in, busy/done/sum/carry/overflow out
//
// Operation:
//   IDLE --start--> RUN (WIDTH cycles) --> DONE (1 cycle) --> IDLE,
//   or DONE --start--> RUN for back-to-back operations. Start is ignored
//   while RUN. Operands, mode and effective carry-in are latched on the
//   accepted start, so the inputs may change freely afterwards.
// ---------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);

    // Bit counter is clog2(WIDTH) wide, with a floor of one bit for WIDTH=1.
    localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Single full-adder slice: returns {carry_out, sum_bit}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        logic s;
        logic co;
        s  = a ^ b ^ c;
        co = (a & b) | (c & (a ^ b));
        return {co, s};
    endfunction

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_c;
    logic             r_carry;
    logic             r_ovf;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_last;
    logic             w_a_bit;
    logic             w_b_bit;
    logic [1:0]       w_fa;

    // A start is only honoured when no bits are in flight; the DONE cycle
    // counts as free so that operations can run back to back.
    always_comb begin
        w_accept = bus.start && (r_state != S_RUN);
        w_last   = (r_cnt == CNT_LAST);
        w_a_bit  = r_a[r_cnt];
        w_b_bit  = r_b[r_cnt];
        w_fa     = full_add(w_a_bit, w_b_bit, r_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_c     <= 1'b0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        // Subtract is folded into the add path: invert B and
                        // force the carry-in to 1 (two's complement negate).
                        r_a     <= bus.i1;
                        r_b     <= bus.sub ? ~bus.i2 : bus.i2;
                        r_c     <= bus.sub ? 1'b1 : bus.cin;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                        r_carry <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                S_RUN: begin
                    r_sum[r_cnt] <= w_fa[0];
                    r_c          <= w_fa[1];
                    if (w_last) begin
                        // On the MSB the registered carry is the carry into
                        // the MSB, so overflow falls out directly.
                        r_carry <= w_fa[1];
                        r_ovf   <= r_c ^ w_fa[1];
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = (r_state == S_RUN);
    assign bus.done     = (r_state == S_DONE);
    assign bus.sum      = r_sum;
    assign bus.carry    = r_carry;
    assign bus.overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    serial_adder_if #(.WIDTH(8)) bus8();
    serial_adder_if #(.WIDTH(1)) bus1();

    serial_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_adder #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int w, input logic [7:0] a, input logic [7:0] b,
                          input logic ci, input logic sb, input logic st);
        if (w == 8) begin
            bus8.i1 = a; bus8.i2 = b; bus8.cin = ci; bus8.sub = sb; bus8.start = st;
        end else begin
            bus1.i1 = a[0]; bus1.i2 = b[0]; bus1.cin = ci; bus1.sub = sb; bus1.start = st;
        end
    endtask

    task automatic scramble(input int w);
        set_in(w, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    endtask

    // {busy, done, carry, overflow, sum[7:0]}
    function automatic logic [11:0] get_out(input int w);
        if (w == 8)
            return {bus8.busy, bus8.done, bus8.carry, bus8.overflow, bus8.sum};
        else
            return {bus1.busy, bus1.done, bus1.carry, bus1.overflow, 7'b0, bus1.sum};
    endfunction

    // Reference: whole-word arithmetic on the operands.
    task automatic model(input int w, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic sb,
                         output logic [7:0] s, output logic c, output logic o);
        int unsigned mask, av, bv, cv, full, msb;
        mask = (32'd1 << w) - 1;
        av   = a & mask;
        bv   = (sb ? {24'b0, ~b} : {24'b0, b}) & mask;
        cv   = sb ? 1 : {31'b0, ci};
        full = av + bv + cv;
        msb  = w - 1;
        s    = 8'(full & mask);
        c    = 1'((full >> w) & 1);
        o    = (((av >> msb) & 1) == ((bv >> msb) & 1)) &&
               (((full >> msb) & 1) != ((av >> msb) & 1));
    endtask

    // Drives one operation from an idle/done cycle and returns in the done cycle.
    task automatic do_op(input int w, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic sb,
                         output logic [7:0] s, output logic c, output logic o,
                         output int lat, output logic hs_ok);
        logic [11:0] q;
        bit got;
        set_in(w, a, b, ci, sb, 1'b1);
        step();
        scramble(w);
        lat = 1; hs_ok = 1'b1; got = 0; q = '0;
        for (int k = 0; k < 40 && !got; k++) begin
            q = get_out(w);
            if (q[10]) begin
                got = 1;
                if (q[11]) hs_ok = 1'b0;
            end else begin
                if (!q[11]) hs_ok = 1'b0;
                step();
                lat++;
                scramble(w);
            end
        end
        if (!got) lat = -1;
        s = q[7:0]; c = q[9]; o = q[8];
    endtask

    task automatic test_reset();
        logic [11:0] q8, q1;
        rst = 1'b1;
        set_in(8, 8'hAA, 8'h55, 1'b1, 1'b0, 1'b1);
        set_in(1, 8'h01, 8'h01, 1'b1, 1'b0, 1'b1);
        step(); step();
        q8 = get_out(8); q1 = get_out(1);
        total_cnt++;
        if (q8 !== 12'h000) $display("FAIL reset_w8: got %h expected 000", q8);
        else pass_cnt++;
        total_cnt++;
        if (q1 !== 12'h000) $display("FAIL reset_w1: got %h expected 000", q1);
        else pass_cnt++;
        rst = 1'b0;
        set_in(8, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        set_in(1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_add();
        logic [7:0] ta [5] = '{8'h0F, 8'hFF, 8'h7F, 8'h00, 8'hC8};
        logic [7:0] tb [5] = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h9C};
        logic       tc [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0] s, es; logic c, o, ec, eo, hs; int lat;
        logic [11:0] q;
        for (int i = 0; i < 5; i++) begin
            model(8, ta[i], tb[i], tc[i], 1'b0, es, ec, eo);
            do_op(8, ta[i], tb[i], tc[i], 1'b0, s, c, o, lat, hs);
            total_cnt++;
            if ({s, c, o, lat, hs} !== {es, ec, eo, 32'(9), 1'b1})
                $display("FAIL add_%0d: got sum=%h c=%b ovf=%b lat=%0d hs=%b expected sum=%h c=%b ovf=%b lat=9",
                         i, s, c, o, lat, hs, es, ec, eo);
            else pass_cnt++;
        end
        // result must hold while idle
        set_in(8, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        step(); step(); step();
        q = get_out(8);
        total_cnt++;
        if (q !== {2'b00, ec, eo, es})
            $display("FAIL add_hold: got %h expected %h", q, {2'b00, ec, eo, es});
        else pass_cnt++;
    endtask

    task automatic test_sub();
        logic [7:0] ta [4] = '{8'h05, 8'h80, 8'h00, 8'h7F};
        logic [7:0] tb [4] = '{8'h07, 8'h01, 8'h00, 8'hFF};
        logic [7:0] s, es; logic c, o, ec, eo, hs; int lat;
        for (int i = 0; i < 4; i++) begin
            // cin is set to 1 to confirm it is ignored in subtract mode
            model(8, ta[i], tb[i], 1'b1, 1'b1, es, ec, eo);
            do_op(8, ta[i], tb[i], 1'b1, 1'b1, s, c, o, lat, hs);
            total_cnt++;
            if ({s, c, o, lat, hs} !== {es, ec, eo, 32'(9), 1'b1})
                $display("FAIL sub_%0d: got sum=%h c=%b ovf=%b lat=%0d hs=%b expected sum=%h c=%b ovf=%b lat=9",
                         i, s, c, o, lat, hs, es, ec, eo);
            else pass_cnt++;
        end
    endtask

    task automatic test_ignore_start();
        int done_cyc = -1;
        int pulses = 0;
        logic [7:0] dsum = 8'h00;
        set_in(8, 8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
        for (int cyc = 1; cyc <= 14; cyc++) begin
            step();
            set_in(8, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), cyc == 3);
            if (bus8.done) begin
                pulses++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    dsum = bus8.sum;
                end
            end
        end
        set_in(8, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        total_cnt++;
        if ({done_cyc, pulses, dsum} !== {32'(9), 32'(1), 8'h46})
            $display("FAIL ignore_start: got done_cyc=%0d pulses=%0d sum=%h expected 9 1 46",
                     done_cyc, pulses, dsum);
        else pass_cnt++;
    endtask

    task automatic test_reset_midop();
        logic [11:0] q;
        bit busy_seen = 0;
        logic [7:0] s, es; logic c, o, ec, eo, hs; int lat;
        set_in(8, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);
        step();
        scramble(8);
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        q = get_out(8);
        total_cnt++;
        if (q !== 12'h000) $display("FAIL reset_midop: got %h expected 000", q);
        else pass_cnt++;
        for (int k = 0; k < 12; k++) begin
            step();
            if (bus8.busy || bus8.done) busy_seen = 1;
        end
        total_cnt++;
        if (busy_seen !== 1'b0) $display("FAIL reset_idle: got activity=%b expected 0", busy_seen);
        else pass_cnt++;
        model(8, 8'h21, 8'h43, 1'b1, 1'b0, es, ec, eo);
        do_op(8, 8'h21, 8'h43, 1'b1, 1'b0, s, c, o, lat, hs);
        total_cnt++;
        if ({s, c, o, lat, hs} !== {es, ec, eo, 32'(9), 1'b1})
            $display("FAIL after_reset: got sum=%h c=%b ovf=%b lat=%0d hs=%b expected sum=%h c=%b ovf=%b lat=9",
                     s, c, o, lat, hs, es, ec, eo);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back(input int w);
        logic [7:0] es1, es2; logic ec1, eo1, ec2, eo2;
        logic [11:0] q;
        int lat;
        bit got;
        model(w, 8'h3C, 8'h0A, 1'b1, 1'b0, es1, ec1, eo1);
        model(w, 8'h10, 8'h21, 1'b0, 1'b1, es2, ec2, eo2);
        set_in(w, 8'h3C, 8'h0A, 1'b1, 1'b0, 1'b1);
        step();
        scramble(w);
        got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            if (get_out(w) & 12'h400) got = 1;
            else begin step(); scramble(w); end
        end
        q = get_out(w);
        total_cnt++;
        if (q !== {2'b01, ec1, eo1, es1})
            $display("FAIL b2b_first_w%0d: got %h expected %h", w, q, {2'b01, ec1, eo1, es1});
        else pass_cnt++;
        // start held in the done cycle
        set_in(w, 8'h10, 8'h21, 1'b0, 1'b1, 1'b1);
        step();
        q = get_out(w);
        total_cnt++;
        if (q[11:8] !== 4'b1000)
            $display("FAIL b2b_accept_w%0d: got busy/done/c/ovf=%b expected 1000", w, q[11:8]);
        else pass_cnt++;
        scramble(w);
        lat = 1; got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            if (get_out(w) & 12'h400) got = 1;
            else begin step(); lat++; scramble(w); end
        end
        if (!got) lat = -1;
        q = get_out(w);
        total_cnt++;
        if ({lat, q} !== {32'(w + 1), 2'b01, ec2, eo2, es2})
            $display("FAIL b2b_second_w%0d: got lat=%0d out=%h expected lat=%0d out=%h",
                     w, lat, q, w + 1, {2'b01, ec2, eo2, es2});
        else pass_cnt++;
        set_in(w, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_width1();
        logic [7:0] ta [6] = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00};
        logic [7:0] tb [6] = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h01, 8'h01};
        logic       tc [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic       ts [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] s, es; logic c, o, ec, eo, hs; int lat;
        for (int i = 0; i < 6; i++) begin
            model(1, ta[i], tb[i], tc[i], ts[i], es, ec, eo);
            do_op(1, ta[i], tb[i], tc[i], ts[i], s, c, o, lat, hs);
            total_cnt++;
            if ({s, c, o, lat, hs} !== {es, ec, eo, 32'(2), 1'b1})
                $display("FAIL w1_%0d: got sum=%h c=%b ovf=%b lat=%0d hs=%b expected sum=%h c=%b ovf=%b lat=2",
                         i, s, c, o, lat, hs, es, ec, eo);
            else pass_cnt++;
        end
        set_in(1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_random(input int w, input int n);
        logic [7:0] a, b, s, es; logic ci, sb, c, o, ec, eo, hs; int lat;
        for (int i = 0; i < n; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            ci = 1'($urandom); sb = 1'($urandom);
            model(w, a, b, ci, sb, es, ec, eo);
            do_op(w, a, b, ci, sb, s, c, o, lat, hs);
            total_cnt++;
            if ({s, c, o, lat, hs} !== {es, ec, eo, 32'(w + 1), 1'b1})
                $display("FAIL rand_w%0d_%0d: a=%h b=%h cin=%b sub=%b got sum=%h c=%b ovf=%b lat=%0d hs=%b expected sum=%h c=%b ovf=%b",
                         w, i, a, b, ci, sb, s, c, o, lat, hs, es, ec, eo);
            else pass_cnt++;
        end
        set_in(w, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        step();
    endtask

    initial begin
        set_in(8, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        set_in(1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_add();
        test_sub();
        test_ignore_start();
        test_reset_midop();
        test_back_to_back(8);
        test_back_to_back(1);
        test_width1();
        test_random(8, 40);
        test_random(1, 20);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
